// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler
//
// Read-side scheduler that shares one output channel among PORT_NUM
// show-ahead FIFO read ports. In IDLE it picks a non-empty port; in BURST it
// pops up to BURST_MAX words from that port and forwards each word through a
// registered valid/ready output stage. Ports are then visited round-robin.
//
// Optional build macro:
//   FIFO_SCHED_FIXED_PRIO_EN - when defined, IDLE always scans from port 0
//                              (lowest-index non-empty port wins) and the
//                              round-robin pointer does not exist.
//
// Ports:
//   rd_clk        read-domain clock
//   rst_n         asynchronous active-low reset
//   fifo_empty    per-port FIFO empty flag
//   fifo_rd_data  per-port show-ahead head word, port i at [i*DATA_BIT +: DATA_BIT]
//   fifo_rd_en    per-port pop strobe (one-hot or zero), combinational
//   out_data      forwarded word
//   out_port      source port of out_data
//   out_valid     out_data is valid
//   out_ready     downstream accepts the word
//   busy          high while a burst is in progress

module fifo_rr_scheduler #(
    parameter int DATA_BIT  = 16,
    parameter int PORT_NUM  = 4,
    parameter int BURST_MAX = 8,
    parameter int PORT_W    = $clog2(PORT_NUM)
) (
    input  logic                         rd_clk,
    input  logic                         rst_n,
    input  logic [PORT_NUM-1:0]          fifo_empty,
    input  logic [PORT_NUM*DATA_BIT-1:0] fifo_rd_data,
    output logic [PORT_NUM-1:0]          fifo_rd_en,
    output logic [DATA_BIT-1:0]          out_data,
    output logic [PORT_W-1:0]            out_port,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);

    localparam int                CNT_W     = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_MAX - 1);
    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(PORT_NUM - 1);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t               state_reg, state_next;
    logic [PORT_W-1:0]    grant_reg, grant_next;
    logic [CNT_W-1:0]     beat_cnt_reg, beat_cnt_next;
    logic [DATA_BIT-1:0]  out_data_reg, out_data_next;
    logic [PORT_W-1:0]    out_port_reg, out_port_next;
    logic                 out_valid_reg, out_valid_next;

    logic [PORT_W-1:0]    scan_start;
`ifndef FIFO_SCHED_FIXED_PRIO_EN
    logic [PORT_W-1:0]    ptr_reg, ptr_next;
    assign scan_start = ptr_reg;
`else
    assign scan_start = '0;
`endif

    // Per-port view of the packed head-word bus.
    logic [DATA_BIT-1:0] port_data [PORT_NUM];

    // Candidate port at scan offset gi, i.e. (scan_start + gi) mod PORT_NUM.
    // Both addends are below PORT_NUM, so a single conditional subtract wraps
    // correctly even when PORT_NUM is not a power of two.
    logic [PORT_W-1:0]   cand_idx [PORT_NUM];
    logic [PORT_NUM-1:0] cand_ne;

    genvar gi;
    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : gen_port
            logic [PORT_W:0] cand_sum;

            assign port_data[gi] = fifo_rd_data[gi*DATA_BIT +: DATA_BIT];
            assign cand_sum      = {1'b0, scan_start} + (PORT_W+1)'(gi);
            assign cand_idx[gi]  = (cand_sum >= (PORT_W+1)'(PORT_NUM))
                                 ? PORT_W'(cand_sum - (PORT_W+1)'(PORT_NUM))
                                 : cand_sum[PORT_W-1:0];
            assign cand_ne[gi]   = ~fifo_empty[cand_idx[gi]];
        end
    endgenerate

    // First non-empty candidate in scan order. Walking from the far end lets
    // the smallest offset overwrite the others.
    logic              scan_found;
    logic [PORT_W-1:0] scan_sel;

    always_comb begin
        scan_found = 1'b0;
        scan_sel   = '0;
        for (int k = PORT_NUM - 1; k >= 0; k--) begin
            if (cand_ne[k]) begin
                scan_found = 1'b1;
                scan_sel   = cand_idx[k];
            end
        end
    end

    logic grant_empty;
    logic slot_free;
    logic pop;

    assign grant_empty = fifo_empty[grant_reg];
    // The output register can take a new word if it is empty or being drained.
    assign slot_free   = ~out_valid_reg | out_ready;
    assign pop         = (state_reg == ST_BURST) & ~grant_empty & slot_free;
    assign fifo_rd_en  = pop ? ({{(PORT_NUM-1){1'b0}}, 1'b1} << grant_reg) : '0;

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        beat_cnt_next  = beat_cnt_reg;
        out_data_next  = out_data_reg;
        out_port_next  = out_port_reg;
        out_valid_next = out_valid_reg;
`ifndef FIFO_SCHED_FIXED_PRIO_EN
        ptr_next       = ptr_reg;
`endif

        // Output stage: load on pop, otherwise drain on ready (in either state).
        if (pop) begin
            out_data_next  = port_data[grant_reg];
            out_port_next  = grant_reg;
            out_valid_next = 1'b1;
            beat_cnt_next  = beat_cnt_reg + CNT_W'(1);
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (scan_found) begin
                    grant_next    = scan_sel;
                    beat_cnt_next = '0;
                    state_next    = ST_BURST;
                end
            end
            ST_BURST: begin
                // An empty granted FIFO ends the burst in that same cycle.
                if (grant_empty || (pop && (beat_cnt_reg == LAST_BEAT))) begin
                    state_next = ST_IDLE;
`ifndef FIFO_SCHED_FIXED_PRIO_EN
                    ptr_next   = (grant_reg == LAST_PORT) ? '0 : grant_reg + PORT_W'(1);
`endif
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            beat_cnt_reg  <= '0;
            out_data_reg  <= '0;
            out_port_reg  <= '0;
            out_valid_reg <= 1'b0;
`ifndef FIFO_SCHED_FIXED_PRIO_EN
            ptr_reg       <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            beat_cnt_reg  <= beat_cnt_next;
            out_data_reg  <= out_data_next;
            out_port_reg  <= out_port_next;
            out_valid_reg <= out_valid_next;
`ifndef FIFO_SCHED_FIXED_PRIO_EN
            ptr_reg       <= ptr_next;
`endif
        end
    end

    assign out_data  = out_data_reg;
    assign out_port  = out_port_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg == ST_BURST);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Testbench for fifo_rr_scheduler: FIFOs are modelled as queues, the
// scheduler as a burst-level reference model, plus a per-port in-order
// scoreboard and directed literal expectations.

module tb_fifo_rr_scheduler;

    localparam int NP = 4;
    localparam int BM = 8;
    localparam int DW = 16;

    logic               rd_clk = 1'b0;
    logic               rst_n  = 1'b0;
    logic [NP-1:0]      fifo_empty;
    logic [NP*DW-1:0]   fifo_rd_data;
    logic [NP-1:0]      fifo_rd_en;
    logic [DW-1:0]      out_data;
    logic [1:0]         out_port;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    always #5 rd_clk = ~rd_clk;

    fifo_rr_scheduler #(
        .DATA_BIT  (DW),
        .PORT_NUM  (NP),
        .BURST_MAX (BM)
    ) dut (
        .rd_clk       (rd_clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .out_data     (out_data),
        .out_port     (out_port),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    // FIFO contents and word numbering
    logic [DW-1:0] q [NP][$];
    int            wr_seq  [NP];
    int            exp_seq [NP];

    // Reference model of the scheduler
    bit            m_busy;
    bit            m_valid;
    int            m_grant;
    int            m_ptr;
    int            m_taken;
    logic [DW-1:0] m_data;
    int            m_port;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            acc_ports [$];
    logic [DW-1:0] acc_data  [$];
    logic [NP-1:0] en_hist   [$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input int p, input int s);
        return DW'(p * 4096 + (s % 4096));
    endfunction

    function automatic int acc_port(input int k);
        return (k < acc_ports.size()) ? acc_ports[k] : -1;
    endfunction

    task automatic drive_fifo();
        for (int i = 0; i < NP; i++) begin
            fifo_empty[i]            = (q[i].size() == 0);
            fifo_rd_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : '0;
        end
    endtask

    task automatic push(input int p);
        q[p].push_back(word_of(p, wr_seq[p]));
        wr_seq[p]++;
        drive_fifo();
    endtask

    task automatic reset_model();
        m_busy = 0; m_valid = 0; m_grant = 0; m_ptr = 0; m_taken = 0;
        m_data = '0; m_port = 0;
        for (int i = 0; i < NP; i++) begin
            q[i].delete();
            wr_seq[i]  = 0;
            exp_seq[i] = 0;
        end
    endtask

    // Compare DUT outputs against the model; record accepted words.
    task automatic check_outputs();
        logic [NP-1:0] exp_en;
        int p;
        exp_en = '0;
        if (m_busy && q[m_grant].size() != 0 && (!m_valid || out_ready))
            exp_en[m_grant] = 1'b1;
        chk("fifo_rd_en", fifo_rd_en, exp_en);
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("out_port", out_port, m_port);
        chk("busy", busy, m_busy);
        if (out_valid && out_ready) begin
            p = int'(out_port);
            $display("xfer port %0d data %h at %0t", p, out_data, $time);
            chk("sb_data", out_data, word_of(p, exp_seq[p]));
            exp_seq[p]++;
            acc_ports.push_back(p);
            acc_data.push_back(out_data);
        end
    endtask

    // One clock of the model: arbitration in idle, one word per free slot
    // inside a burst, burst closes after BM words or on an empty FIFO.
    task automatic advance();
        bit pop;
        bit done;
        int start;
        bit found;
        pop = m_busy && q[m_grant].size() != 0 && (!m_valid || out_ready);
        if (!m_busy) begin
            if (m_valid && out_ready) m_valid = 0;
`ifdef FIFO_SCHED_FIXED_PRIO_EN
            start = 0;
`else
            start = m_ptr;
`endif
            found = 0;
            for (int k = 0; k < NP; k++) begin
                if (!found && q[(start + k) % NP].size() != 0) begin
                    found   = 1;
                    m_busy  = 1;
                    m_grant = (start + k) % NP;
                    m_taken = 0;
                end
            end
        end else begin
            done = (q[m_grant].size() == 0);
            if (pop) begin
                m_valid = 1;
                m_data  = q[m_grant][0];
                m_port  = m_grant;
                m_taken++;
                if (m_taken == BM) done = 1;
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (done) begin
                m_busy = 0;
                m_ptr  = (m_grant + 1) % NP;
            end
        end
    endtask

    task automatic cycle();
        logic [NP-1:0] s_en;
        @(negedge rd_clk);
        check_outputs();
        s_en = fifo_rd_en;
        en_hist.push_back(s_en);
        @(posedge rd_clk);
        #1;
        advance();
        for (int i = 0; i < NP; i++)
            if (s_en[i] && q[i].size() != 0) void'(q[i].pop_front());
        drive_fifo();
    endtask

    task automatic do_reset();
        @(negedge rd_clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_port", out_port, 0);
        chk("rst_fifo_rd_en", fifo_rd_en, 0);
        chk("rst_busy", busy, 0);
        reset_model();
        drive_fifo();
        @(posedge rd_clk);
        #1;
        rst_n = 1'b1;
        chk("rst_busy_after_release", busy, 0);
    endtask

    task automatic run_until_acc(input int n, input int budget, input string nm);
        int c = 0;
        while (acc_ports.size() < n && c < budget) begin
            cycle();
            c++;
        end
        chk({nm, "_words_in_budget"}, acc_ports.size() >= n, 1);
    endtask

    initial begin
        int cnt, first, last, e;
        out_ready    = 1'b0;
        fifo_empty   = '1;
        fifo_rd_data = '0;
        reset_model();
        drive_fifo();

        // Power-on reset values
        #3;
        chk("por_out_valid", out_valid, 0);
        chk("por_out_data", out_data, 0);
        chk("por_out_port", out_port, 0);
        chk("por_fifo_rd_en", fifo_rd_en, 0);
        chk("por_busy", busy, 0);
        @(posedge rd_clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-burst with a word held in the output register
        for (int i = 0; i < 5; i++) push(0);
        out_ready = 1'b0;
        repeat (3) cycle();
        chk("t1_valid_before_reset", out_valid, 1);
        chk("t1_busy_before_reset", busy, 1);
        do_reset();

        // Single port, three words
        acc_ports.delete(); acc_data.delete(); en_hist.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(0);
        repeat (8) cycle();
        cnt = 0; first = -1; last = -1;
        foreach (en_hist[i]) begin
            if (en_hist[i][0]) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("t2_pop_count", cnt, 3);
        chk("t2_pop_span", last - first, 2);
        chk("t2_words", acc_data.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("t2_data", (i < acc_data.size()) ? acc_data[i] : 16'hdead, 16'h0000 + 16'(i));
        acc_ports.delete(); acc_data.delete();
        push(0);
        push(1);
        repeat (6) cycle();
`ifdef FIFO_SCHED_FIXED_PRIO_EN
        chk("t2_next_grant", acc_port(0), 0);
`else
        chk("t2_next_grant", acc_port(0), 1);
`endif

        // Fairness: 4 ports x 20 words
        do_reset();
        acc_ports.delete(); acc_data.delete();
        out_ready = 1'b1;
        for (int p = 0; p < NP; p++)
            for (int i = 0; i < 20; i++) push(p);
        run_until_acc(80, 300, "t3");
        repeat (5) cycle();
        chk("t3_total", acc_ports.size(), 80);
        for (int k = 0; k < 80; k++) begin
`ifdef FIFO_SCHED_FIXED_PRIO_EN
            e = k / 20;
`else
            e = (k < 64) ? (k / 8) % 4 : (k - 64) / 4;
`endif
            chk("t3_order", acc_port(k), e);
        end

        // Backpressure inside a burst on port 2
        do_reset();
        acc_ports.delete(); acc_data.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(2);
        run_until_acc(3, 50, "t4_pre");
        out_ready = 1'b0;
        chk("t4_held_data", out_data, 16'h2003);
        en_hist.delete();
        repeat (5) cycle();
        cnt = 0;
        foreach (en_hist[i]) if (en_hist[i] != '0) cnt++;
        chk("t4_stall_pops", cnt, 0);
        chk("t4_held_data_after", out_data, 16'h2003);
        chk("t4_held_port_after", out_port, 2);
        out_ready = 1'b1;
        run_until_acc(8, 50, "t4_post");
        for (int i = 0; i < 8; i++)
            chk("t4_data", (i < acc_data.size()) ? acc_data[i] : 16'hdead, 16'h2000 + 16'(i));

        // Pointer wrap after a port-3 burst
        acc_ports.delete(); acc_data.delete();
        for (int i = 0; i < 2; i++) begin
            push(3); push(0); push(2);
        end
        run_until_acc(6, 60, "t5");
        for (int k = 0; k < 6; k++) begin
`ifdef FIFO_SCHED_FIXED_PRIO_EN
            e = (k < 2) ? 0 : (k < 4) ? 2 : 3;
`else
            e = (k < 2) ? 3 : (k < 4) ? 0 : 2;
`endif
            chk("t5_order", acc_port(k), e);
        end

        // Ports 1 and 2 both loaded
        acc_ports.delete(); acc_data.delete();
        for (int i = 0; i < 12; i++) begin
            push(1); push(2);
        end
        run_until_acc(24, 100, "t6");
        for (int k = 0; k < 24; k++) begin
`ifdef FIFO_SCHED_FIXED_PRIO_EN
            e = (k < 12) ? 1 : 2;
`else
            e = (k < 8) ? 1 : (k < 16) ? 2 : (k < 20) ? 1 : 2;
`endif
            chk("t6_order", acc_port(k), e);
        end

        // Random traffic and backpressure, with one reset in the middle
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) do_reset();
            out_ready = ($urandom_range(3) != 0);
            for (int p = 0; p < NP; p++)
                if (q[p].size() < 12 && $urandom_range(3) == 0) push(p);
            cycle();
        end
        out_ready = 1'b1;
        repeat (200) cycle();
        for (int p = 0; p < NP; p++)
            chk("rand_all_delivered", exp_seq[p], wr_seq[p]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
